// File: rtl/first_one_iterator_if.sv
// Handshake bundle for first_one_iterator: a vector input channel, the per-bit
// output channel and the flush/busy sideband.
interface first_one_iterator_if #(
    parameter int WIDTH = 8
);
  localparam int INDEX_WIDTH = $clog2(WIDTH);

  logic                   flush;
  logic [WIDTH-1:0]       data;
  logic                   data_valid;
  logic                   data_ready;
  logic [WIDTH-1:0]       first_onehot;
  logic [INDEX_WIDTH-1:0] first_index;
  logic                   first_last;
  logic                   first_valid;
  logic                   first_ready;
  logic                   busy;

  // master: the producer/consumer around the iterator
  modport master (
    output flush, data, data_valid, first_ready,
    input  data_ready, first_onehot, first_index, first_last, first_valid, busy
  );

  // slave: the iterator itself
  modport slave (
    input  flush, data, data_valid, first_ready,
    output data_ready, first_onehot, first_index, first_last, first_valid, busy
  );
endinterface

// File: rtl/first_one_iterator.sv
// Sequential set-bit iterator: accepts a vector and returns its set bits one per
// output handshake as one-hot mask + binary index, lowest- or highest-first.
module first_one_iterator #(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
    input logic                clock,
    input logic                resetn,
    first_one_iterator_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       remaining_reg, remaining_next;
  logic [WIDTH-1:0]       scan_vec;
  logic [WIDTH-1:0]       scan_iso;
  logic [WIDTH-1:0]       onehot;
  logic [INDEX_WIDTH-1:0] index;
  logic                   busy;
  logic                   last;
  logic                   handshake;
  logic                   data_nonzero;
  logic                   data_ready;

  // MSB-first is handled by bit-reversing into and out of an LSB isolator.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_rev
        assign scan_vec[gi] = remaining_reg[WIDTH-1-gi];
        assign onehot[gi]   = scan_iso[WIDTH-1-gi];
      end else begin : g_fwd
        assign scan_vec[gi] = remaining_reg[gi];
        assign onehot[gi]   = scan_iso[gi];
      end
    end
  endgenerate

  assign scan_iso = scan_vec & (~scan_vec + WIDTH'(1));

  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        index = index | INDEX_WIDTH'(i);
      end
    end
  end

  assign busy         = (state_reg == SCAN);
  assign last         = busy && ((remaining_reg & ~onehot) == '0);
  assign handshake    = busy && bus.first_ready;
  assign data_nonzero = (bus.data != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
    end
  end

  // Flush overrides everything, including a handshake in the same cycle.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    data_ready     = 1'b0;
    if (bus.flush) begin
      state_next     = IDLE;
      remaining_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          data_ready = 1'b1;
          if (bus.data_valid && data_nonzero) begin
            state_next     = SCAN;
            remaining_next = bus.data;
          end
        end
        SCAN: begin
          if (handshake) begin
            if (last) begin
              // Final bit consumed: a waiting vector loads on this same edge.
              data_ready = 1'b1;
              if (bus.data_valid && data_nonzero) begin
                state_next     = SCAN;
                remaining_next = bus.data;
              end else begin
                state_next     = IDLE;
                remaining_next = '0;
              end
            end else begin
              remaining_next = remaining_reg & ~onehot;
            end
          end
        end
        default: begin
          state_next     = IDLE;
          remaining_next = '0;
        end
      endcase
    end
  end

  assign bus.data_ready   = data_ready;
  assign bus.first_onehot = busy ? onehot : '0;
  assign bus.first_index  = busy ? index : '0;
  assign bus.first_last   = last;
  assign bus.first_valid  = busy;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_first_one_iterator.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; expected
// outputs are queued per instance and checked by a negedge monitor.
module tb_first_one_iterator;

  logic       clock;
  logic       resetn;
  logic       flush;
  logic [7:0] data;
  logic       data_valid;
  logic       first_ready;

  int checks = 0;
  int errors = 0;

  logic [11:0] q_lsb[$];
  logic [11:0] q_msb[$];

  first_one_iterator_if #(.WIDTH(8)) if_lsb ();
  first_one_iterator_if #(.WIDTH(8)) if_msb ();

  assign if_lsb.flush       = flush;
  assign if_lsb.data        = data;
  assign if_lsb.data_valid  = data_valid;
  assign if_lsb.first_ready = first_ready;
  assign if_msb.flush       = flush;
  assign if_msb.data        = data;
  assign if_msb.data_valid  = data_valid;
  assign if_msb.first_ready = first_ready;

  first_one_iterator #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock (clock),
    .resetn(resetn),
    .bus   (if_lsb.slave)
  );

  first_one_iterator #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock (clock),
    .resetn(resetn),
    .bus   (if_msb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit msb, input logic [7:0] oh, input logic [2:0] idx, input logic lst);
    if (msb) q_msb.push_back({oh, idx, lst});
    else     q_lsb.push_back({oh, idx, lst});
  endtask

  task automatic mon(input bit msb, input logic v, input logic r, input logic [11:0] got);
    logic [11:0] exp;
    string name;
    name = msb ? "msb" : "lsb";
    if (v) begin
      if ((msb ? q_msb.size() : q_lsb.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got %03h required no output", name, got);
      end else begin
        exp = msb ? q_msb[0] : q_lsb[0];
        chk({name, "_out"}, {20'd0, got}, {20'd0, exp});
        if (r) begin
          if (msb) void'(q_msb.pop_front());
          else     void'(q_lsb.pop_front());
          $display("[%0t] %s out onehot=%02h index=%0d last=%0b",
                   $time, name, got[11:4], got[3:1], got[0]);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_lsb_valid"},  {31'd0, if_lsb.first_valid},  32'd0);
    chk({tag, "_lsb_onehot"}, {24'd0, if_lsb.first_onehot}, 32'd0);
    chk({tag, "_lsb_index"},  {29'd0, if_lsb.first_index},  32'd0);
    chk({tag, "_lsb_last"},   {31'd0, if_lsb.first_last},   32'd0);
    chk({tag, "_lsb_busy"},   {31'd0, if_lsb.busy},         32'd0);
    chk({tag, "_lsb_ready"},  {31'd0, if_lsb.data_ready},   32'd1);
    chk({tag, "_msb_valid"},  {31'd0, if_msb.first_valid},  32'd0);
    chk({tag, "_msb_onehot"}, {24'd0, if_msb.first_onehot}, 32'd0);
    chk({tag, "_msb_busy"},   {31'd0, if_msb.busy},         32'd0);
    chk({tag, "_msb_ready"},  {31'd0, if_msb.data_ready},   32'd1);
  endtask

  // Presents v until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] v);
    int n;
    data       = v;
    data_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!(if_lsb.data_ready && if_msb.data_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("send_%02h_ready", v), {31'd0, if_lsb.data_ready & if_msb.data_ready}, 32'd1);
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    data       = 8'h00;
  endtask

  // Counts busy cycles (sampled at negedge) until both instances are idle.
  task automatic wait_idle(input string name, input int exp_cycles);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (!if_lsb.busy && !if_msb.busy) done = 1'b1;
      else begin
        n++;
        if (n > 200) done = 1'b1;
      end
    end
    chk(name, n, exp_cycles);
  endtask

  initial begin
    logic [3:0] pat;
    int k, n;
    bit done;
    resetn      = 1'b0;
    flush       = 1'b0;
    data        = 8'h00;
    data_valid  = 1'b0;
    first_ready = 1'b1;

    fork
      begin
        @(negedge clock);
        check_idle_outputs("in_reset");
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check_idle_outputs("after_reset");
        @(posedge clock);
        #1;

        // Sparse vector: LSB 2,5,7 / MSB 7,5,2
        push(0, 8'h04, 3'd2, 1'b0); push(0, 8'h20, 3'd5, 1'b0); push(0, 8'h80, 3'd7, 1'b1);
        push(1, 8'h80, 3'd7, 1'b0); push(1, 8'h20, 3'd5, 1'b0); push(1, 8'h04, 3'd2, 1'b1);
        send(8'hA4);
        wait_idle("a4_cycles", 3);

        // Zero vector: accepted, no output
        send(8'h00);
        wait_idle("zero_cycles", 0);
        @(posedge clock);
        #1;

        // Back-to-back: 81 then 02 held valid
        push(0, 8'h01, 3'd0, 1'b0); push(0, 8'h80, 3'd7, 1'b1); push(0, 8'h02, 3'd1, 1'b1);
        push(1, 8'h80, 3'd7, 1'b0); push(1, 8'h01, 3'd0, 1'b1); push(1, 8'h02, 3'd1, 1'b1);
        data = 8'h81; data_valid = 1'b1;
        @(negedge clock);
        chk("b2b_ready_idle", {31'd0, if_lsb.data_ready}, 32'd1);
        @(posedge clock);
        #1 data = 8'h02;
        @(negedge clock);
        chk("b2b_ready_notlast", {31'd0, if_lsb.data_ready | if_msb.data_ready}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("b2b_ready_last", {31'd0, if_lsb.data_ready & if_msb.data_ready}, 32'd1);
        @(posedge clock);
        #1 data_valid = 1'b0; data = 8'h00;
        wait_idle("b2b_tail_cycles", 1);
        @(posedge clock);
        #1;

        // Full vector with first_ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) begin
          push(0, 8'h01 << i, 3'(i), i == 7);
          push(1, 8'h80 >> i, 3'(7 - i), i == 7);
        end
        pat = 4'b1001;
        send(8'hFF);
        k = 0; n = 0; done = 1'b0;
        first_ready = pat[0];
        while (!done) begin
          @(negedge clock);
          if (!if_lsb.busy && !if_msb.busy) done = 1'b1;
          else begin
            n++;
            @(posedge clock);
            #1;
            k++;
            first_ready = pat[k % 4];
            if (n > 100) done = 1'b1;
          end
        end
        chk("ff_stall_cycles", n, 16);
        first_ready = 1'b1;
        @(posedge clock);
        #1;

        // Flush after two outputs; a vector offered in the flush cycle is refused
        push(0, 8'h01, 3'd0, 1'b0); push(0, 8'h02, 3'd1, 1'b0);
        push(1, 8'h08, 3'd3, 1'b0); push(1, 8'h04, 3'd2, 1'b0);
        send(8'h0F);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 flush = 1'b1; data = 8'h55; data_valid = 1'b1;
        @(negedge clock);
        chk("flush_ready", {31'd0, if_lsb.data_ready | if_msb.data_ready}, 32'd0);
        @(posedge clock);
        #1 flush = 1'b0; data_valid = 1'b0; data = 8'h00;
        @(negedge clock);
        chk("flush_busy", {31'd0, if_lsb.busy | if_msb.busy}, 32'd0);
        @(posedge clock);
        #1;

        // Reset pulse after two outputs
        push(0, 8'h01, 3'd0, 1'b0); push(0, 8'h02, 3'd1, 1'b0);
        push(1, 8'h08, 3'd3, 1'b0); push(1, 8'h04, 3'd2, 1'b0);
        send(8'h0F);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 resetn = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("post_reset_busy", {31'd0, if_lsb.busy | if_msb.busy}, 32'd0);
        @(posedge clock);
        #1;
      end
      begin
        forever begin
          @(negedge clock);
          if (resetn && !flush) begin
            mon(0, if_lsb.first_valid, first_ready,
                {if_lsb.first_onehot, if_lsb.first_index, if_lsb.first_last});
            mon(1, if_msb.first_valid, first_ready,
                {if_msb.first_onehot, if_msb.first_index, if_msb.first_last});
          end
        end
      end
    join_any
    disable fork;

    chk("lsb_queue_empty", q_lsb.size(), 0);
    chk("msb_queue_empty", q_msb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
